ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch stage that sits directly upstream of decode/execute.
- Owns the architectural PC register and issues one instruction-memory request per instruction.
- Presents the fetched instruction and its PC to decode over a valid/ready handshake.
- Non-pipelined: after hand-off it waits for the execute stage's next-PC commit (the execute stage's new-PC output) before fetching again.

Parameters:
- DATA_WIDTH, 64, PC and address width.
- INST_WIDTH, 32, instruction word width.
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- next_pc_i  input  DATA_WIDTH  next PC from execute.
- next_pc_valid_i  input  1  one-cycle pulse; next_pc_i is committed.
- imem_req_valid_o  input/output: output  1  fetch request valid.
- imem_req_ready_i  input  1  memory accepts the request.
- imem_addr_o  output  DATA_WIDTH  fetch address (equals pc_o).
- imem_resp_valid_i  input  1  one-cycle response pulse.
- imem_resp_data_i  input  INST_WIDTH  fetched instruction.
- imem_resp_err_i  input  1  access fault, qualified by imem_resp_valid_i.
- inst_valid_o  output  1  instruction valid to decode.
- inst_ready_i  input  1  decode accepts the instruction.
- inst_o  output  INST_WIDTH  held instruction.
- pc_o  output  DATA_WIDTH  PC of the current instruction.
- fetch_error_o  output  2  one-hot: bit0 MISALIGNED, bit1 ACCESS_FAULT.

Behaviour:
- Reset: one clock; asynchronous active-high rst.
  - Values on reset: state=S_REQ, pc=RESET_PC, inst_o=0, fetch_error_o=0.
  - On the first clock after release, imem_req_valid_o=1 (if RESET_PC is aligned).
- State S_REQ:
  - If pc[1:0]!=0: fetch_error_o[0]=1, go to S_ERR; no request is issued.
  - Otherwise imem_req_valid_o=1 and imem_addr_o=pc.
  - Both are held stable until imem_req_ready_i. When valid&ready, go to S_WAIT.
- State S_WAIT:
  - imem_req_valid_o=0; wait for imem_resp_valid_i.
  - On a response with err=1: fetch_error_o[1]=1, go to S_ERR.
  - On a response with err=0: latch inst_o=imem_resp_data_i, go to S_VALID.
  - Response latency is unbounded, minimum 1 cycle after acceptance.
- State S_VALID:
  - inst_valid_o=1; inst_o and pc_o are stable.
  - On inst_valid_o&inst_ready_i, go to S_EXEC.
  - Ready may be asserted in the same cycle valid rises; the hand-off then takes exactly 1 cycle.
- State S_EXEC:
  - inst_valid_o=0; wait for next_pc_valid_i.
  - On the pulse: pc<=next_pc_i, go to S_REQ.
- State S_ERR:
  - Terminal; all outputs held, fetch_error_o sticky. Only rst exits.
- Ignored inputs:
  - next_pc_valid_i is ignored outside S_EXEC.
  - imem_resp_valid_i is ignored outside S_WAIT.
  - imem_req_ready_i is ignored when imem_req_valid_o=0.
- Best-case latency: redirect pulse → next inst_valid_o is 3 cycles with ready=1 and a 1-cycle response (S_REQ, S_WAIT, S_VALID).
- PC arithmetic: the full DATA_WIDTH is taken from next_pc_i unmodified; no wrap checking. 64'hFFFF_FFFF_FFFF_FFFC is fetched normally.
- rst asserted mid-operation (any state): immediate return to reset values. A response arriving later for the pre-reset request is discarded because the state is S_REQ, not S_WAIT.
- fetch_error_o is never multi-hot; the first error wins.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - fetch_cnt_o, 64 bits: count of completed decode hand-offs.
  - stall_cnt_o, 64 bits: count of cycles spent in S_REQ with ready=0, plus cycles in S_WAIT.
- Both counters reset to 0, wrap modulo 2^64, and freeze in S_ERR.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ifu_pkg holds:
  - state encoding S_REQ=0, S_WAIT=1, S_VALID=2, S_EXEC=3, S_ERR=4 (3 bits);
  - error indices FE_MISALIGNED=0, FE_ACCESS_FAULT=1;
  - the RESET_PC default.
- Sub-module ifu_perf_cnt (the two counters) is instantiated only under IFU_PERF_CNT_EN.
- The FSM and PC register stay in ifu_fetch.

Test Plan:
- Reset release, ready=1, response 1 cycle later with data 32'h00000013 → imem_addr_o=RESET_PC on the first request; inst_valid_o=1 with inst_o=32'h00000013 and pc_o=RESET_PC on the 3rd cycle.
- imem_req_ready_i held 0 for 4 cycles → imem_req_valid_o=1 and imem_addr_o unchanged all 4 cycles; exactly one request accepted.
- Hand-off, then next_pc_valid_i pulse with next_pc_i=64'h8000_0100 → the next request address is 64'h8000_0100; a spurious next_pc_valid_i pulse while in S_VALID has no effect.
- next_pc_i=64'h8000_0102 → no request issued; fetch_error_o=2'b01 and sticky until rst.
- Response with imem_resp_err_i=1 → fetch_error_o=2'b10; inst_valid_o stays 0.
- rst pulsed while in S_WAIT, then a late response arrives → it is ignored; a fresh request to RESET_PC is issued. With IFU_PERF_CNT_EN, after 3 hand-offs fetch_cnt_o=3.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// fetch error bit indices and the default reset PC.
package ifu_pkg;

   typedef enum logic [2:0] {
      S_REQ   = 3'd0,
      S_WAIT  = 3'd1,
      S_VALID = 3'd2,
      S_EXEC  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam int FE_MISALIGNED   = 0;
   localparam int FE_ACCESS_FAULT = 1;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Fetch performance counters: completed decode hand-offs and stall cycles.
// Only instantiated when IFU_PERF_CNT_EN is defined. Counters wrap naturally.
module ifu_perf_cnt #(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 handoff,
   input  logic                 stall,
   output logic [CNT_WIDTH-1:0] fetch_cnt,
   output logic [CNT_WIDTH-1:0] stall_cnt
);

   logic [1:0]                inc;
   logic [1:0][CNT_WIDTH-1:0] cnt_all;

   assign inc = {stall, handoff};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_WIDTH-1:0] cnt_reg;

         // Increment this counter on every qualifying cycle.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               cnt_reg <= '0;
            else if (inc[gi])
               cnt_reg <= cnt_reg + CNT_WIDTH'(1);
         end

         assign cnt_all[gi] = cnt_reg;
      end
   endgenerate

   assign fetch_cnt = cnt_all[0];
   assign stall_cnt = cnt_all[1];

endmodule

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch stage. Owns the PC, issues one memory
// request per instruction, hands the instruction to decode, then waits for
// the execute stage to commit the next PC. Errors are terminal until reset.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int                    DATA_WIDTH = 64,
   parameter int                    INST_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT[DATA_WIDTH-1:0]
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] next_pc_i,
   input  logic                  next_pc_valid_i,
   output logic                  imem_req_valid_o,
   input  logic                  imem_req_ready_i,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_resp_valid_i,
   input  logic [INST_WIDTH-1:0] imem_resp_data_i,
   input  logic                  imem_resp_err_i,
   output logic                  inst_valid_o,
   input  logic                  inst_ready_i,
   output logic [INST_WIDTH-1:0] inst_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic [1:0]            fetch_error_o
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [63:0]           fetch_cnt_o,
   output logic [63:0]           stall_cnt_o
`endif
);

   state_t                state_reg, state_next;
   logic [DATA_WIDTH-1:0] pc_reg, pc_next;
   logic [INST_WIDTH-1:0] inst_reg, inst_next;
   logic [1:0]            err_reg, err_next;
   logic                  aligned;

   assign aligned = (pc_reg[1:0] == 2'b00);

   // State, PC, held instruction and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_REQ;
         pc_reg    <= RESET_PC;
         inst_reg  <= '0;
         err_reg   <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         inst_reg  <= inst_next;
         err_reg   <= err_next;
      end
   end

   // Next-state logic and handshake outputs; errors are only raised from
   // non-error states, so the error vector can never become multi-hot.
   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      inst_next        = inst_reg;
      err_next         = err_reg;
      imem_req_valid_o = 1'b0;
      inst_valid_o     = 1'b0;

      case (state_reg)
         S_REQ: begin
            if (!aligned) begin
               err_next[FE_MISALIGNED] = 1'b1;
               state_next              = S_ERR;
            end else begin
               imem_req_valid_o = 1'b1;
               if (imem_req_ready_i)
                  state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid_i) begin
               if (imem_resp_err_i) begin
                  err_next[FE_ACCESS_FAULT] = 1'b1;
                  state_next                = S_ERR;
               end else begin
                  inst_next  = imem_resp_data_i;
                  state_next = S_VALID;
               end
            end
         end
         S_VALID: begin
            inst_valid_o = 1'b1;
            if (inst_ready_i)
               state_next = S_EXEC;
         end
         S_EXEC: begin
            if (next_pc_valid_i) begin
               pc_next    = next_pc_i;
               state_next = S_REQ;
            end
         end
         S_ERR: begin
            state_next = S_ERR;
         end
         default: begin
            state_next = S_REQ;
         end
      endcase
   end

   assign imem_addr_o   = pc_reg;
   assign pc_o          = pc_reg;
   assign inst_o        = inst_reg;
   assign fetch_error_o = err_reg;

`ifdef IFU_PERF_CNT_EN
   logic handoff;
   logic stall;

   assign handoff = (state_reg == S_VALID) && inst_ready_i;
   assign stall   = ((state_reg == S_REQ) && !imem_req_ready_i) || (state_reg == S_WAIT);

   ifu_perf_cnt #(
      .CNT_WIDTH (64)
   ) u_perf_cnt (
      .clk       (clk),
      .rst       (rst),
      .handoff   (handoff),
      .stall     (stall),
      .fetch_cnt (fetch_cnt_o),
      .stall_cnt (stall_cnt_o)
   );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic [63:0] next_pc_i;
    logic        next_pc_valid_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_addr_o;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        imem_resp_err_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic [1:0]  fetch_error_o;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] fetch_cnt_o;
    logic [63:0] stall_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    ifu_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .next_pc_i         (next_pc_i),
        .next_pc_valid_i   (next_pc_valid_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_addr_o       (imem_addr_o),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .imem_resp_err_i   (imem_resp_err_i),
        .inst_valid_o      (inst_valid_o),
        .inst_ready_i      (inst_ready_i),
        .inst_o            (inst_o),
        .pc_o              (pc_o),
        .fetch_error_o     (fetch_error_o)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_cnt_o       (fetch_cnt_o),
        .stall_cnt_o       (stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        next_pc_i         = '0;
        next_pc_valid_i   = 1'b0;
        imem_req_ready_i  = 1'b0;
        imem_resp_valid_i = 1'b0;
        imem_resp_data_i  = '0;
        imem_resp_err_i   = 1'b0;
        inst_ready_i      = 1'b0;

        tick();
        tick();
        check("rst_pc", pc_o, RPC);
        check("rst_inst", inst_o, 32'h0);
        check("rst_err", fetch_error_o, 2'b00);
        check("rst_ivalid", inst_valid_o, 1'b0);
`ifdef IFU_PERF_CNT_EN
        check("rst_fcnt", fetch_cnt_o, 64'd0);
`endif

        rst              = 1'b0;
        imem_req_ready_i = 1'b1;
        check("f1_reqv", imem_req_valid_o, 1'b1);
        check("f1_addr", imem_addr_o, RPC);
        tick();
        imem_req_ready_i = 1'b0;
        check("f1_wait_reqv", imem_req_valid_o, 1'b0);
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = 32'h0000_0013;
        tick();
        imem_resp_valid_i = 1'b0;
        check("f1_ivalid", inst_valid_o, 1'b1);
        check("f1_inst", inst_o, 32'h0000_0013);
        check("f1_pc", pc_o, RPC);
        next_pc_i       = 64'h0000_0000_0000_1234;
        next_pc_valid_i = 1'b1;
        tick();
        next_pc_valid_i = 1'b0;
        check("spur_ivalid", inst_valid_o, 1'b1);
        check("spur_pc", pc_o, RPC);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        $display("handoff 1 pc=%0h inst=%0h", RPC, 32'h13);
        check("f1_exec_ivalid", inst_valid_o, 1'b0);
        check("f1_exec_reqv", imem_req_valid_o, 1'b0);

        next_pc_i       = 64'h0000_0000_8000_0100;
        next_pc_valid_i = 1'b1;
        tick();
        next_pc_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_reqv", imem_req_valid_o, 1'b1);
            check("bp_addr", imem_addr_o, 64'h0000_0000_8000_0100);
            tick();
        end
        imem_req_ready_i = 1'b1;
        check("bp_accept_reqv", imem_req_valid_o, 1'b1);
        tick();
        check("bp_wait_reqv0", imem_req_valid_o, 1'b0);
        tick();
        check("bp_wait_reqv1", imem_req_valid_o, 1'b0);
        check("bp_wait_ivalid", inst_valid_o, 1'b0);
        imem_req_ready_i  = 1'b0;
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = 32'hDEAD_BEEF;
        inst_ready_i      = 1'b1;
        tick();
        imem_resp_valid_i = 1'b0;
        check("f2_ivalid", inst_valid_o, 1'b1);
        check("f2_inst", inst_o, 32'hDEAD_BEEF);
        check("f2_pc", pc_o, 64'h0000_0000_8000_0100);
        tick();
        inst_ready_i = 1'b0;
        $display("handoff 2 pc=%0h inst=%0h", 64'h80000100, 32'hDEADBEEF);
        check("f2_exec_ivalid", inst_valid_o, 1'b0);

        next_pc_i       = 64'hFFFF_FFFF_FFFF_FFFC;
        next_pc_valid_i = 1'b1;
        tick();
        next_pc_valid_i = 1'b0;
        check("top_reqv", imem_req_valid_o, 1'b1);
        check("top_addr", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i  = 1'b0;
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = 32'h1234_5678;
        tick();
        imem_resp_valid_i = 1'b0;
        check("top_inst", inst_o, 32'h1234_5678);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        $display("handoff 3 pc=%0h inst=%0h", 64'hFFFFFFFFFFFFFFFC, 32'h12345678);
`ifdef IFU_PERF_CNT_EN
        check("fcnt3", fetch_cnt_o, 64'd3);
`endif

        next_pc_i       = 64'h0000_0000_8000_0102;
        next_pc_valid_i = 1'b1;
        tick();
        next_pc_valid_i  = 1'b0;
        imem_req_ready_i = 1'b1;
        check("mis_reqv", imem_req_valid_o, 1'b0);
        tick();
        check("mis_err", fetch_error_o, 2'b01);
        imem_resp_valid_i = 1'b1;
        imem_resp_err_i   = 1'b1;
        next_pc_i         = 64'h0000_0000_8000_0000;
        next_pc_valid_i   = 1'b1;
        tick();
        tick();
        imem_resp_valid_i = 1'b0;
        imem_resp_err_i   = 1'b0;
        next_pc_valid_i   = 1'b0;
        imem_req_ready_i  = 1'b0;
        $display("misaligned fetch pc=%0h", 64'h80000102);
        check("mis_sticky", fetch_error_o, 2'b01);
        check("mis_reqv_held", imem_req_valid_o, 1'b0);
        check("mis_pc_held", pc_o, 64'h0000_0000_8000_0102);

        rst = 1'b1;
        #2;
        check("rst2_err", fetch_error_o, 2'b00);
        rst              = 1'b0;
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i  = 1'b0;
        imem_resp_valid_i = 1'b1;
        imem_resp_err_i   = 1'b1;
        imem_resp_data_i  = 32'hAAAA_AAAA;
        tick();
        imem_resp_valid_i = 1'b0;
        imem_resp_err_i   = 1'b0;
        $display("access fault pc=%0h", RPC);
        check("af_err", fetch_error_o, 2'b10);
        check("af_ivalid", inst_valid_o, 1'b0);
        check("af_inst", inst_o, 32'h0);
        tick();
        check("af_sticky", fetch_error_o, 2'b10);

        rst = 1'b1;
        #2;
        rst              = 1'b0;
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        check("rw_wait_reqv", imem_req_valid_o, 1'b0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        check("rw_err_clr", fetch_error_o, 2'b00);
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = 32'hBAD0_BAD0;
        tick();
        imem_resp_valid_i = 1'b0;
        check("rw_late_ivalid", inst_valid_o, 1'b0);
        check("rw_late_reqv", imem_req_valid_o, 1'b1);
        check("rw_late_addr", imem_addr_o, RPC);
        check("rw_late_inst", inst_o, 32'h0);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i  = 1'b0;
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = 32'h0000_0055;
        tick();
        imem_resp_valid_i = 1'b0;
        $display("refetch after reset pc=%0h inst=%0h", RPC, 32'h55);
        check("rw_ivalid", inst_valid_o, 1'b1);
        check("rw_inst", inst_o, 32'h0000_0055);
        check("rw_pc", pc_o, RPC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
